layer_argmax: RTL

LAYER_ARGMAX -- requirements
Module: layer_argmax

---
 rtl/layer_argmax_pkg.sv | 19 +
 rtl/layer_argmax_cmp.sv | 29 ++
 rtl/layer_argmax.sv | 128 ++++++++++++
 3 files changed

// File: rtl/layer_argmax_pkg.sv
// Shared constants and state encoding for the argmax output layer.
// Optional build macro: ARGMAX_TIE_LAST_EN (ties resolve to the highest index).
package layer_argmax_pkg;

  // Default frame geometry: ten signed 8-bit neuron scores.
  localparam int N_NEURONS_DEF = 10;
  localparam int DATA_W_DEF    = 8;

  // Width of the neuron index and the scan counter.
  localparam int IDX_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer_argmax_cmp.sv
// Signed compare-and-select of one candidate score against the running best.
// Optional build macro: ARGMAX_TIE_LAST_EN (equal scores replace the best).
module argmax_cmp
  import layer_argmax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_cand_val,
  input  logic [IDX_W-1:0]  i_cand_idx,
  input  logic [DATA_W-1:0] i_best_val,
  input  logic [IDX_W-1:0]  i_best_idx,
  output logic [DATA_W-1:0] o_sel_val,
  output logic [IDX_W-1:0]  o_sel_idx
);

  logic w_take;

  // Scores are two's-complement; the candidate wins on strictly greater,
  // or on greater-or-equal when ties should favour later neurons.
`ifdef ARGMAX_TIE_LAST_EN
  assign w_take = ($signed(i_cand_val) >= $signed(i_best_val));
`else
  assign w_take = ($signed(i_cand_val) > $signed(i_best_val));
`endif

  assign o_sel_val = w_take ? i_cand_val : i_best_val;
  assign o_sel_idx = w_take ? i_cand_idx : i_best_idx;

endmodule

// File: rtl/layer_argmax.sv
// Argmax output layer: captures a frame of neuron scores, scans them one per
// cycle and presents the winning index/score until the consumer acknowledges.
// Optional build macro: ARGMAX_TIE_LAST_EN (ties resolve to the highest index).
module layer_argmax
  import layer_argmax_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ready,
  input  logic [N_NEURONS*DATA_W-1:0] neuron_out,
  output logic                        received,
  input  logic                        result_ack,
  output logic                        done,
  output logic [IDX_W-1:0]            class_idx,
  output logic [DATA_W-1:0]           class_val
);

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] w_scores [N_NEURONS];
  logic [DATA_W-1:0] r_bank   [N_NEURONS];

  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_best_val;
  logic [IDX_W-1:0]  r_best_idx;
  logic [IDX_W-1:0]  r_class_idx;
  logic [DATA_W-1:0] r_class_val;
  logic              r_received;

  logic              w_capture;
  logic              w_last;
  logic [DATA_W-1:0] w_sel_val;
  logic [IDX_W-1:0]  w_sel_idx;

  assign w_capture = (r_state == S_IDLE) && ready;
  assign w_last    = (r_cnt == IDX_W'(N_NEURONS - 1));

  // Unpack the flat score bus (neuron 0 in the least significant byte) and
  // latch every score into the bank on the capture edge; the bank is not reset.
  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_bank
    assign w_scores[gi] = neuron_out[gi*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
      if (w_capture) begin
        r_bank[gi] <= w_scores[gi];
      end
    end
  end

  argmax_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .i_cand_val (r_bank[r_cnt]),
    .i_cand_idx (r_cnt),
    .i_best_val (r_best_val),
    .i_best_idx (r_best_idx),
    .o_sel_val  (w_sel_val),
    .o_sel_idx  (w_sel_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: ready only matters in IDLE, result_ack only in DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (ready)      w_state_next = S_SCAN;
      S_SCAN:  if (w_last)     w_state_next = S_DONE;
      S_DONE:  if (result_ack) w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  // Scan datapath: seed with neuron 0, fold in one neuron per edge, and
  // publish the final winner on the edge that processes the last neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_received  <= 1'b0;
      r_cnt       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_class_idx <= '0;
      r_class_val <= '0;
    end else begin
      r_received <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_best_val <= w_scores[0];
            r_best_idx <= '0;
            r_cnt      <= IDX_W'(1);
            r_received <= 1'b1;
          end
        end
        S_SCAN: begin
          r_best_val <= w_sel_val;
          r_best_idx <= w_sel_idx;
          if (w_last) begin
            r_cnt       <= '0;
            r_class_idx <= w_sel_idx;
            r_class_val <= w_sel_val;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign received  = r_received;
  assign done      = (r_state == S_DONE);
  assign class_idx = r_class_idx;
  assign class_val = r_class_val;

endmodule
